// File: rtl/adder.sv
// Registered 5-bit unsigned adder with bit-level operand ports.
// A ripple-carry chain of five full adders feeds a single output register.
module adder (
  input  logic clk,
  input  logic rst,
  input  logic a4,
  input  logic a3,
  input  logic a2,
  input  logic a1,
  input  logic a0,
  input  logic b4,
  input  logic b3,
  input  logic b2,
  input  logic b1,
  input  logic b0,
  output logic q4,
  output logic q3,
  output logic q2,
  output logic q1,
  output logic q0,
  output logic overflow
);

  logic [4:0] a;
  logic [4:0] b;
  logic [4:0] sum;
  logic [5:0] carry;
  logic [4:0] q_r;
  logic       overflow_r;

  assign a = {a4, a3, a2, a1, a0};
  assign b = {b4, b3, b2, b1, b0};

  // Explicit full-adder chain; carry[i] is the carry into stage i.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < 5; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r        <= '0;
      overflow_r <= 1'b0;
    end else begin
      q_r        <= sum;
      overflow_r <= carry[5];
    end
  end

  // Outputs come straight from the register: no input-to-output path.
  assign q4       = q_r[4];
  assign q3       = q_r[3];
  assign q2       = q_r[2];
  assign q1       = q_r[1];
  assign q0       = q_r[0];
  assign overflow = overflow_r;

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: reset, carry chain, extremes, latency,
// async reset, back-to-back traffic and a full 32x32 operand sweep.
module tb_adder;

  logic       clk;
  logic       rst;
  logic [4:0] a;
  logic [4:0] b;
  logic [4:0] q;
  logic       overflow;

  logic [5:0] exp_q[$];
  int         vec_count;
  int         miscompares;

  adder dut (
    .clk      (clk),
    .rst      (rst),
    .a4       (a[4]),
    .a3       (a[3]),
    .a2       (a[2]),
    .a1       (a[1]),
    .a0       (a[0]),
    .b4       (b[4]),
    .b3       (b[3]),
    .b2       (b[2]),
    .b1       (b[1]),
    .b0       (b[0]),
    .q4       (q[4]),
    .q3       (q[3]),
    .q2       (q[2]),
    .q1       (q[1]),
    .q0       (q[0]),
    .overflow (overflow)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Observed value packed as {overflow, q}
  function automatic logic [5:0] observed();
    return {overflow, q};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got q=%0d ovf=%b, required q=%0d ovf=%b",
               tag, got[4:0], got[5], exp[4:0], exp[5]);
    end
  endtask

  // Drive one operand pair before an edge and check it one cycle later.
  task automatic drive_and_check(input logic [4:0] va, input logic [4:0] vb,
                                 input logic [5:0] exp, input string tag);
    logic [5:0] e;
    @(negedge clk);
    a = va;
    b = vb;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, observed(), e);
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    rst = 1'b1;
    a   = 5'd0;
    b   = 5'd0;

    // Reset state before any clock edge
    #1;
    check("reset_state", observed(), 6'd0);

    @(negedge clk);
    rst = 1'b0;

    // Hand-computed directed vectors: {overflow, q}
    drive_and_check(5'd0,  5'd0,  6'd0,  "zero_plus_zero");
    drive_and_check(5'd15, 5'd1,  6'd16, "carry_chain_15_1");
    drive_and_check(5'd31, 5'd1,  6'd32, "wrap_31_1");
    drive_and_check(5'd31, 5'd31, 6'd62, "max_31_31");
    drive_and_check(5'd10, 5'd5,  6'd15, "plain_10_5");
    drive_and_check(5'd21, 5'd10, 6'd31, "no_carry_out_21_10");

    // Latency: nothing moves before the edge, nothing moves mid-cycle
    @(negedge clk);
    a = 5'd3;
    b = 5'd4;
    #3;
    check("latency_before_edge", observed(), 6'd31);
    @(posedge clk);
    #1;
    check("latency_after_edge", observed(), 6'd7);
    #2;
    a = 5'd9;
    b = 5'd9;
    #1;
    check("midcycle_input_change", observed(), 6'd7);

    // Async reset raised between edges, released with 20 + 15 waiting
    rst = 1'b1;
    #1;
    check("async_reset_immediate", observed(), 6'd0);
    a = 5'd20;
    b = 5'd15;
    #2;
    rst = 1'b0;
    #1;
    check("reset_release_no_edge", observed(), 6'd0);
    @(posedge clk);
    #1;
    check("first_edge_after_reset", observed(), 6'd35);

    // Back-to-back, one result per clock
    drive_and_check(5'd1,  5'd1,  6'd2,  "b2b_1_1");
    drive_and_check(5'd2,  5'd2,  6'd4,  "b2b_2_2");
    drive_and_check(5'd16, 5'd16, 6'd32, "b2b_16_16");

    // Small corner first, then the full operand space
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        drive_and_check(i[4:0], j[4:0], 6'(i + j), $sformatf("small_%0d_%0d", i, j));
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        drive_and_check(i[4:0], j[4:0], 6'(i + j), $sformatf("sweep_%0d_%0d", i, j));

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
